// File: rtl/alu_calc_trig.sv
// Iterative Taylor-series sine/cosine for angles in [-pi/2, +pi/2], built around one shared
// signed multiplier; each series term costs two cycles (scale by 1/n, then by x).
module alu_calc_trig #(
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned FRAC_W  = 16,
  parameter int unsigned N_TERMS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     mode,
  input  logic                     do_calc,
  output logic signed [DATA_W-1:0] result,
  output logic                     calc_done,
  output logic                     busy
);

  localparam int unsigned     TermW = DATA_W + 2;
  localparam int unsigned     AccW  = DATA_W + 4;
  localparam int unsigned     ProdW = 2 * TermW;
  localparam logic [3:0]      NLast = 4'(N_TERMS);
  localparam longint unsigned One   = 64'd1 << FRAC_W;

  typedef enum logic [2:0] {StIdle, StLoad, StMulCoef, StMulX, StDone} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic                     mode_q, mode_d;
  logic signed [TermW-1:0]  term_q, term_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic [3:0]               n_q, n_d;
  logic signed [DATA_W-1:0] result_q, result_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic signed [TermW-1:0]  mul_b;
  logic signed [ProdW-1:0]  prod;
  logic signed [TermW-1:0]  term_nx;
  logic signed [AccW-1:0]   term_ext;

  // round(2^FRAC_W / k), all constants folded at elaboration.
  function automatic logic signed [TermW-1:0] recip(input logic [3:0] k);
    longint unsigned r;
    case (k)
      4'd1:    r = One;
      4'd2:    r = (64'd2 * One + 64'd2) / 64'd4;
      4'd3:    r = (64'd2 * One + 64'd3) / 64'd6;
      4'd4:    r = (64'd2 * One + 64'd4) / 64'd8;
      4'd5:    r = (64'd2 * One + 64'd5) / 64'd10;
      4'd6:    r = (64'd2 * One + 64'd6) / 64'd12;
      4'd7:    r = (64'd2 * One + 64'd7) / 64'd14;
      4'd8:    r = (64'd2 * One + 64'd8) / 64'd16;
      4'd9:    r = (64'd2 * One + 64'd9) / 64'd18;
      4'd10:   r = (64'd2 * One + 64'd10) / 64'd20;
      4'd11:   r = (64'd2 * One + 64'd11) / 64'd22;
      4'd12:   r = (64'd2 * One + 64'd12) / 64'd24;
      default: r = 64'd0;
    endcase
    return TermW'(r);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [AccW-1:0] a);
    logic [AccW-DATA_W:0] top;
    top = a[AccW-1:DATA_W-1];
    if (top == '0 || top == '1) begin
      return a[DATA_W-1:0];
    end else if (a[AccW-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  // Shared multiplier: coefficient operand in MUL_COEF, captured angle in MUL_X.
  always_comb begin
    mul_b    = (state_q == StMulX) ? {{(TermW-DATA_W){x_q[DATA_W-1]}}, x_q} : recip(n_q);
    prod     = ProdW'(term_q) * ProdW'(mul_b);
    term_nx  = TermW'(prod >>> FRAC_W);
    term_ext = AccW'(term_nx);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    mode_d   = mode_q;
    term_d   = term_q;
    acc_d    = acc_q;
    n_d      = n_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: begin
        if (do_calc) begin
          x_d     = x_in;
          mode_d  = mode;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        term_d  = TermW'(One);
        acc_d   = mode_q ? '0 : AccW'(One);
        n_d     = 4'd1;
        state_d = StMulCoef;
      end
      StMulCoef: begin
        term_d  = term_nx;
        state_d = StMulX;
      end
      StMulX: begin
        term_d = term_nx;
        // Cosine keeps even powers, sine odd powers, each with alternating sign.
        case ({mode_q, n_q[1:0]})
          3'b0_00, 3'b1_01: acc_d = acc_q + term_ext;
          3'b0_10, 3'b1_11: acc_d = acc_q - term_ext;
          default:          acc_d = acc_q;
        endcase
        n_d = n_q + 4'd1;
        if (n_q < NLast) begin
          state_d = StMulCoef;
        end else begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = sat(acc_d);
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      mode_q   <= 1'b0;
      term_q   <= '0;
      acc_q    <= '0;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      mode_q   <= mode_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      n_q      <= n_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result    = result_q;
  assign calc_done = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_calc_trig.sv
// Randomised bench for alu_calc_trig: results against a fixed-point series model and the
// ideal sin/cos, plus latency, input-capture, reset-abort and throughput scenarios.
module tb_alu_calc_trig;

  localparam int DW  = 18;
  localparam int FW  = 16;
  localparam int NT  = 10;
  localparam int LAT = 2 * NT + 2;
  localparam int PER = 2 * NT + 3;
  localparam int HALF_PI = 102944;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mode;
  logic                 do_calc;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] result;
  logic                 calc_done;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  int vx[5]   = '{0, HALF_PI, HALF_PI, -HALF_PI, 0};
  bit vm[5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int vexp[5] = '{65536, 65536, 0, -65536, 0};
  int vtol[5] = '{2, 8, 8, 8, 0};

  alu_calc_trig #(.DATA_W(DW), .FRAC_W(FW), .N_TERMS(NT)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .mode      (mode),
    .do_calc   (do_calc),
    .result    (result),
    .calc_done (calc_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Truncated Maclaurin series in fixed point with floor shifts, saturated to DW bits.
  function automatic int model(input int x, input bit m);
    longint one, term, acc, rc, lim;
    int sgn;
    one  = longint'(1) << FW;
    lim  = longint'(1) << (DW - 1);
    term = one;
    acc  = m ? 64'sd0 : one;
    for (int n = 1; n <= NT; n++) begin
      rc   = longint'(int'(real'(one) / real'(n)));
      term = (term * rc) >>> FW;
      term = (term * longint'(x)) >>> FW;
      case (n % 4)
        0:       sgn = m ? 0 : 1;
        1:       sgn = m ? 1 : 0;
        2:       sgn = m ? 0 : -1;
        default: sgn = m ? -1 : 0;
      endcase
      acc = acc + longint'(sgn) * term;
    end
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
    return int'(acc);
  endfunction

  function automatic real ideal(input int x, input bit m);
    real a;
    a = real'(x) / real'(1 << FW);
    return (m ? $sin(a) : $cos(a)) * real'(1 << FW);
  endfunction

  function automatic int rand_x();
    return int'($urandom_range(2 * HALF_PI)) - HALF_PI;
  endfunction

  // Issues one request from IDLE, waits (bounded) for calc_done, returns after DONE.
  task automatic run_calc(input int x, input bit m, output int res, output int lat);
    x_in    = DW'(x);
    mode    = m;
    do_calc = 1'b1;
    @(posedge clk); #1;
    do_calc = 1'b0;
    lat     = 1;
    while (calc_done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = int'(result);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    do_calc = 1'b0;
    x_in    = '0;
    mode    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (result !== '0) begin
      n_fail++; $display("FAIL reset_result: got %0d expected 0", result);
    end
    n_checks++;
    if (calc_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", calc_done);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    int res, lat, exp_m;
    real err;
    for (int i = 0; i < 5; i++) begin
      run_calc(vx[i], vm[i], res, lat);
      exp_m = model(vx[i], vm[i]);
      err   = real'(res - vexp[i]);
      if (err < 0.0) err = -err;
      n_checks++;
      if (lat !== LAT) begin
        n_fail++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, LAT);
      end
      n_checks++;
      if (err > real'(vtol[i])) begin
        n_fail++;
        $display("FAIL vec%0d_value: got %0d expected %0d +/- %0d", i, res, vexp[i], vtol[i]);
      end
      n_checks++;
      if (res !== exp_m) begin
        n_fail++; $display("FAIL vec%0d_model: got %0d expected %0d", i, res, exp_m);
      end
    end
  endtask

  task automatic test_random;
    int x, res, lat, exp_m;
    bit m;
    real err;
    for (int i = 0; i < 24; i++) begin
      x = rand_x();
      m = 1'($urandom_range(1));
      run_calc(x, m, res, lat);
      exp_m = model(x, m);
      err   = real'(res) - ideal(x, m);
      if (err < 0.0) err = -err;
      n_checks++;
      if (lat !== LAT) begin
        n_fail++; $display("FAIL rand_latency x=%0d: got %0d expected %0d", x, lat, LAT);
      end
      n_checks++;
      if (res !== exp_m) begin
        n_fail++; $display("FAIL rand_model x=%0d m=%0d: got %0d expected %0d", x, m, res, exp_m);
      end
      n_checks++;
      if (err > 8.0) begin
        n_fail++;
        $display("FAIL rand_ideal x=%0d m=%0d: got %0d expected %f", x, m, res, ideal(x, m));
      end
    end
  endtask

  task automatic test_ignore;
    int xa, xc, exp_a, exp_c, dones, done_cyc, busy_after, changes, busy_low, lat;
    logic signed [DW-1:0] held;
    xa    = int'($urandom_range(90000, 20000));
    exp_a = model(xa, 1'b1);
    x_in    = DW'(xa);
    mode    = 1'b1;
    do_calc = 1'b1;
    @(posedge clk); #1;
    do_calc = 1'b0;
    x_in    = DW'(-xa);
    mode    = 1'b0;
    dones = 0; done_cyc = 0; busy_after = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (calc_done === 1'b1) begin
        dones++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc >= 23 && busy !== 1'b0) busy_after++;
      do_calc = (cyc == 5 || cyc == 22);
      if (cyc == 5) x_in = DW'(rand_x());
      @(posedge clk); #1;
    end
    do_calc = 1'b0;
    n_checks++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dones);
    end
    n_checks++;
    if (done_cyc !== LAT) begin
      n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", done_cyc, LAT);
    end
    n_checks++;
    if (busy_after !== 0) begin
      n_fail++; $display("FAIL ignore_busy_after: got %0d busy cycles expected 0", busy_after);
    end
    n_checks++;
    if (int'(result) !== exp_a) begin
      n_fail++; $display("FAIL ignore_result: got %0d expected %0d", result, exp_a);
    end

    // result must hold through the next run until its DONE; busy high through DONE.
    held  = result;
    xc    = -xa;
    exp_c = model(xc, 1'b0);
    x_in    = DW'(xc);
    mode    = 1'b0;
    do_calc = 1'b1;
    @(posedge clk); #1;
    do_calc = 1'b0;
    changes = 0; busy_low = 0; lat = 1;
    while (calc_done !== 1'b1 && lat < 200) begin
      if (result !== held) changes++;
      if (busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) busy_low++;
    n_checks++;
    if (changes !== 0) begin
      n_fail++; $display("FAIL hold_result: got %0d changes expected 0", changes);
    end
    n_checks++;
    if (busy_low !== 0) begin
      n_fail++; $display("FAIL hold_busy: got %0d low cycles expected 0", busy_low);
    end
    n_checks++;
    if (int'(result) !== exp_c || lat !== LAT) begin
      n_fail++;
      $display("FAIL hold_next: got %0d lat %0d expected %0d lat %0d", result, lat, exp_c, LAT);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_busy_clear: got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int x, res, lat, dones, busy_hi;
    bit m;
    x = rand_x();
    m = 1'($urandom_range(1));
    x_in    = DW'(x);
    mode    = m;
    do_calc = 1'b1;
    @(posedge clk); #1;
    do_calc = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (calc_done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL abort_state: got done=%b busy=%b result=%0d expected 0 0 0",
               calc_done, busy, result);
    end
    dones = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (calc_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones);
    end
    run_calc(x, m, res, lat);
    n_checks++;
    if (lat !== LAT || res !== model(x, m)) begin
      n_fail++;
      $display("FAIL abort_restart: got %0d lat %0d expected %0d lat %0d",
               res, lat, model(x, m), LAT);
    end

    // Simultaneous reset and do_calc: request dropped.
    reset   = 1'b1;
    do_calc = 1'b1;
    x_in    = DW'(rand_x());
    @(posedge clk); #1;
    reset   = 1'b0;
    do_calc = 1'b0;
    dones = 0; busy_hi = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (calc_done === 1'b1) dones++;
      if (busy !== 1'b0) busy_hi++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones !== 0 || busy_hi !== 0) begin
      n_fail++;
      $display("FAIL reset_wins: got %0d pulses %0d busy cycles expected 0 0", dones, busy_hi);
    end
    n_checks++;
    if (result !== '0) begin
      n_fail++; $display("FAIL reset_wins_result: got %0d expected 0", result);
    end
  endtask

  task automatic test_back_to_back;
    int x, exp_r, times[$], waited;
    bit m;
    x     = rand_x();
    m     = 1'($urandom_range(1));
    exp_r = model(x, m);
    x_in    = DW'(x);
    mode    = m;
    do_calc = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (calc_done === 1'b1) begin
        times.push_back(cyc);
        n_checks++;
        if (int'(result) !== exp_r) begin
          n_fail++; $display("FAIL b2b_result: got %0d expected %0d", result, exp_r);
        end
      end
      @(posedge clk); #1;
    end
    do_calc = 1'b0;
    n_checks++;
    if (times.size() !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses expected 4", times.size());
    end
    if (times.size() > 0) begin
      n_checks++;
      if (times[0] !== LAT) begin
        n_fail++; $display("FAIL b2b_first: got %0d expected %0d", times[0], LAT);
      end
    end
    for (int i = 1; i < times.size(); i++) begin
      n_checks++;
      if (times[i] - times[i-1] !== PER) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, times[i] - times[i-1], PER);
      end
    end
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
